// File: rtl/mips_cpu_pkg.sv
// Shared types and helpers for the MIPS CPU multiply/divide unit.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } multdiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } multdiv_state_t;

  localparam int MULTDIV_ITER = 32;

  // Two's-complement negate of a 32-bit word.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // Two's-complement negate of a 64-bit word.
  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // Magnitude of x when treated as signed; raw value for unsigned ops.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/mips_cpu_multdiv_if.sv
// Request/result bundle between the CPU controller and the mult/div unit.
// Latency: none (wiring only).
// Backpressure: controller holds off new requests while busy is high.
interface mips_cpu_multdiv_if;
  import mips_cpu_pkg::*;

  logic        start;
  multdiv_op_t op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        write_enable;
  logic [31:0] write_data_lo;
  logic [31:0] write_data_hi;

  modport master (
    output start, op, op_a, op_b,
    input  busy, done, write_enable, write_data_lo, write_data_hi
  );

  modport slave (
    input  start, op, op_a, op_b,
    output busy, done, write_enable, write_data_lo, write_data_hi
  );

endinterface

// File: rtl/mips_cpu_multdiv.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit feeding the HI/LO register block.
// Latency: 34 cycles from the start edge to the HI/LO capture edge; one op per 35 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module mips_cpu_multdiv
  import mips_cpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  mips_cpu_multdiv_if.slave        bus
);

  multdiv_state_t state_q, state_d;
  multdiv_op_t    op_q;
  logic [4:0]     cnt_q;
  logic [31:0]    b_q;        // addend (multiply) or divisor (divide)
  logic [32:0]    rem_q;      // upper accumulator (multiply) or partial remainder (divide)
  logic [31:0]    lo_q;       // multiplier/low product or dividend/quotient
  logic           neg_res_q;  // negate product or quotient in FIX
  logic           neg_rem_q;  // negate remainder in FIX
  logic [31:0]    res_hi_q, res_lo_q;

  logic           is_div;
  logic [32:0]    add_x, add_y, add_sum, sel;
  logic [32:0]    rem_d;
  logic [31:0]    lo_d;
  logic [31:0]    a_mag, b_mag;
  logic [63:0]    product;

  assign is_div = op_q[1];

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d          = state_q;
    bus.busy         = 1'b1;
    bus.done         = 1'b0;
    bus.write_enable = 1'b0;
    case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_d = RUN;
      end
      RUN:  if (cnt_q == 5'd0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: begin
        bus.done         = 1'b1;
        bus.write_enable = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One iteration of the shared 33-bit add/subtract datapath.
  always_comb begin
    add_x   = is_div ? {rem_q[31:0], lo_q[31]} : rem_q;
    add_y   = {1'b0, b_q};
    add_sum = add_x + (is_div ? ~add_y : add_y) + {32'd0, is_div};
    sel     = add_x;
    rem_d   = rem_q;
    lo_d    = lo_q;
    if (is_div) begin
      // Restoring division: keep the difference only when it did not borrow.
      sel   = add_sum[32] ? add_x : add_sum;
      rem_d = sel;
      lo_d  = {lo_q[30:0], ~add_sum[32]};
    end else begin
      // Shift-add: conditionally add, then shift the 64-bit accumulator right.
      sel   = lo_q[0] ? add_sum : add_x;
      rem_d = {1'b0, sel[32:1]};
      lo_d  = {sel[0], lo_q[31:1]};
    end
  end

  // Operand magnitudes and the raw product used at FIX.
  always_comb begin
    a_mag   = abs32(bus.op_a, bus.op[0]);
    b_mag   = abs32(bus.op_b, bus.op[0]);
    product = {rem_q[31:0], lo_q};
  end

  // Operand capture, iteration and result registration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= MULTU;
      cnt_q     <= 5'd0;
      b_q       <= 32'd0;
      rem_q     <= 33'd0;
      lo_q      <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_hi_q  <= 32'd0;
      res_lo_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          op_q      <= bus.op;
          cnt_q     <= 5'(MULTDIV_ITER - 1);
          rem_q     <= 33'd0;
          // Multiply walks op_b bit by bit; divide shifts the dividend out of lo.
          b_q       <= bus.op[1] ? b_mag : a_mag;
          lo_q      <= bus.op[1] ? a_mag : b_mag;
          neg_res_q <= bus.op[0] & (bus.op_a[31] ^ bus.op_b[31]);
          neg_rem_q <= bus.op[0] & bus.op[1] & bus.op_a[31];
        end
        RUN: begin
          rem_q <= rem_d;
          lo_q  <= lo_d;
          if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
        end
        FIX: begin
          if (is_div) begin
            res_lo_q <= neg_res_q ? neg32(lo_q) : lo_q;
            res_hi_q <= neg_rem_q ? neg32(rem_q[31:0]) : rem_q[31:0];
          end else begin
            {res_hi_q, res_lo_q} <= neg_res_q ? neg64(product) : product;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.write_data_lo = res_lo_q;
  assign bus.write_data_hi = res_hi_q;

endmodule

// File: tb/tb_mips_cpu_multdiv.sv
// Directed bench for the mult/div unit: reset, idle, arithmetic vectors, hazards.
// Latency: checks the strobe lands 33 edges after the start edge (captured at T+34).
// Backpressure: checks start during RUN is dropped and reset aborts cleanly.
module tb_mips_cpu_multdiv;
  import mips_cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mips_cpu_multdiv_if bus();

  mips_cpu_multdiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and watch 75 edges: strobe count/timing, result, busy, hold.
  task automatic run_op(input string tag, input multdiv_op_t op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit hazard);
    int          strobes = 0;
    int          first   = -1;
    logic [31:0] got_hi  = 32'd0;
    logic [31:0] got_lo  = 32'd0;
    logic        done_ok = 1'b1;
    logic        busy1   = 1'b0;
    logic        busy33  = 1'b0;
    logic        busy34  = 1'b1;
    @(posedge clk); #1;
    bus.op = op; bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 75; n++) begin
      if (hazard && n == 5) begin
        bus.start = 1'b1; bus.op = DIV; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'h3;
      end
      if (hazard && n == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done !== bus.write_enable) done_ok = 1'b0;
      if (bus.write_enable === 1'b1) begin
        strobes++;
        if (first < 0) begin
          first  = n;
          got_hi = bus.write_data_hi;
          got_lo = bus.write_data_lo;
        end
      end
      if (n == 1)  busy1  = bus.busy;
      if (n == 33) busy33 = bus.busy;
      if (n == 34) busy34 = bus.busy;
    end
    check({tag, " strobes"},    64'(strobes), 64'd1);
    check({tag, " strobe_edge"}, 64'(first),  64'd33);
    check({tag, " hi"},          {32'd0, got_hi}, {32'd0, exp_hi});
    check({tag, " lo"},          {32'd0, got_lo}, {32'd0, exp_lo});
    check({tag, " done_eq_we"},  {63'd0, done_ok}, 64'd1);
    check({tag, " busy_rise"},   {63'd0, busy1},   64'd1);
    check({tag, " busy_at_done"}, {63'd0, busy33}, 64'd1);
    check({tag, " busy_fall"},   {63'd0, busy34},  64'd0);
    check({tag, " hold_hi"},     {32'd0, bus.write_data_hi}, {32'd0, exp_hi});
    check({tag, " hold_lo"},     {32'd0, bus.write_data_lo}, {32'd0, exp_lo});
  endtask

  initial begin
    int idle_hits;
    int abort_strobes;

    reset = 1'b1;
    bus.start = 1'b0; bus.op = MULTU; bus.op_a = 32'd0; bus.op_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", {63'd0, bus.busy}, 64'd0);
    check("rst done", {63'd0, bus.done}, 64'd0);
    check("rst we",   {63'd0, bus.write_enable}, 64'd0);
    check("rst lo",   {32'd0, bus.write_data_lo}, 64'd0);
    check("rst hi",   {32'd0, bus.write_data_hi}, 64'd0);
    reset = 1'b0;

    idle_hits = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b0 || bus.write_enable !== 1'b0) idle_hits++;
    end
    check("idle quiet", 64'(idle_hits), 64'd0);

    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",  MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("mult_min",  MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div_neg",   DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_100",  DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_op("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_zero", DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b0);
    run_op("div_zero",  DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'h0000_0001, 1'b0);
    run_op("hazard",    MULTU, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32'h0000_0000, 1'b1);

    // Abort mid-RUN with reset; outputs must clear immediately and no strobe follows.
    @(posedge clk); #1;
    bus.op = MULTU; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'hFFFF_FFFF; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    check("abort busy", {63'd0, bus.busy}, 64'd0);
    check("abort we",   {63'd0, bus.write_enable}, 64'd0);
    check("abort lo",   {32'd0, bus.write_data_lo}, 64'd0);
    check("abort hi",   {32'd0, bus.write_data_hi}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    abort_strobes = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bus.write_enable !== 1'b0) abort_strobes++;
    end
    check("abort no_strobe", 64'(abort_strobes), 64'd0);
    run_op("after_abort", MULT, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
